sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares one 64-bit Avalon-MM SDRAM port between two masters.
//  m0 is the LCD frame-buffer streamer: reads only, latency-critical, high priority.
//  m1 is the drawing/clear engine: reads and writes, low priority, starvation-protected.
//  Read data returns in order; each word is steered to its requester via a tag FIFO.
// PARAMETERS
//  MAX_PENDING   16  outstanding read commands tracked (power of 2)
//  STARVE_LIMIT  32  consecutive m0 grants while m1 waits before m1 is forced in
// PORTS
//  clock            in   1   system clock
//  reset_n          in   1   async active-low reset
//  m0_address       in   29  64-bit word address
//  m0_burstcount    in   8   words per read, 1..255
//  m0_read          in   1   read request
//  m0_waitrequest   out  1   command not accepted this cycle
//  m0_readdata      out  64  read data (shared bus s_readdata)
//  m0_readdatavalid out  1   m0_readdata valid
//  m1_address       in   29  word address
//  m1_burstcount    in   8   words per read/write, 1..255
//  m1_read          in   1   read request
//  m1_write         in   1   write request (never together with m1_read)
//  m1_writedata     in   64  write data
//  m1_byteenable    in   8   byte enables
//  m1_waitrequest   out  1   command not accepted this cycle
//  m1_readdata      out  64  read data
//  m1_readdatavalid out  1   m1_readdata valid
//  address,burstcount,read,write,writedata,byteenable  out  29/8/1/1/64/8  to SDRAM
//  waitrequest,readdata,readdatavalid                  in   1/64/1         from SDRAM
// BEHAVIOUR
//  - Reset: locked=0, owner=0, starve_cnt=0, tag FIFO empty.
//    read=write=0, m*_readdatavalid=0, m*_waitrequest=1 while reset_n low.
//  - req0 = m0_read. req1 = m1_read|m1_write.
//    rd_ok = tag FIFO not full (counts the entry being pushed this cycle).
//  - Per-cycle owner select (combinational):
//    - locked=1: keep the registered owner.
//    - else m1 if req1 && (!req0 || starve_cnt==STARVE_LIMIT); else m0 if req0; else none.
//  - Owner's address/burstcount/writedata/byteenable drive the SDRAM port.
//  - Slave read  = owner's read  & rd_ok. Slave write = owner's write.
//  - Owner's waitrequest = waitrequest | (owner reads & !rd_ok). Non-owner waitrequest = 1.
//  - Lock: locked <= (read|write) & waitrequest. Owner is held until the slave accepts,
//    so the presented command never changes while stalled (Avalon rule).
//  - Accept = (read|write) & !waitrequest. An accepted read pushes {owner, burstcount}.
//  - starve_cnt:
//    - cleared on an m1 accept, or whenever req1=0;
//    - +1 on each m0 accept while req1=1;
//    - saturates at STARVE_LIMIT;
//    - forced grant to m1 lasts until that m1 command is accepted.
//  - Return path:
//    - head entry tags every readdatavalid word; word counter += 1;
//    - pop + counter clear when counter == burstcount-1;
//    - readdata is fanned out to both masters;
//    - m*_readdatavalid = readdatavalid & (head owner == *), same cycle, zero latency.
//  - Simultaneous push and pop in one cycle: the FIFO count stays unchanged.
//  - readdatavalid with the FIFO empty is a slave protocol error. It is dropped: no valid
//    to either master, no state change.
//  - Writes take no tag. m1 write bursts keep owner=m1 until all words are accepted:
//    locked is also held while a write-burst beat counter is nonzero.
//  - Async reset mid-burst discards every tag. The SDRAM controller shares the same reset.
// TESTING
//  - Reset: reset_n=0 -> read=write=0, m0/m1_waitrequest=1, both readdatavalid=0.
//  - m0 reads 0x100..0x10F back-to-back, waitrequest=0:
//    -> 16 accepts in 16 cycles, all return data on m0 only.
//  - Both requesting continuously:
//    -> m1 accepted exactly once per 33 accepts (32 m0 + 1 m1), and never 2 cycles late.
//  - waitrequest=1 for 5 cycles while m0 reads 0x200 and m1 then asserts:
//    -> address stays 0x200 all 5 cycles; m1_waitrequest=1 until m0 accepted.
//  - 16 reads outstanding with readdatavalid held off:
//    -> 17th read stalls with read=0; the first returned word releases it the next cycle.
//  - Interleaved: m1 read burst 4, then m0 read burst 2, data returns in order:
//    -> 4 m1_readdatavalid pulses then 2 m0 pulses; readdatavalid with the FIFO empty
//       is ignored.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of both master ports and the shared SDRAM Avalon-MM port.
// slave = arbiter view, master = environment view (masters + SDRAM controller).
interface sdram_port_arbiter_if;
   logic [28:0] m0_address;
   logic [7:0]  m0_burstcount;
   logic        m0_read;
   logic        m0_waitrequest;
   logic [63:0] m0_readdata;
   logic        m0_readdatavalid;

   logic [28:0] m1_address;
   logic [7:0]  m1_burstcount;
   logic        m1_read;
   logic        m1_write;
   logic [63:0] m1_writedata;
   logic [7:0]  m1_byteenable;
   logic        m1_waitrequest;
   logic [63:0] m1_readdata;
   logic        m1_readdatavalid;

   logic [28:0] address;
   logic [7:0]  burstcount;
   logic        read;
   logic        write;
   logic [63:0] writedata;
   logic [7:0]  byteenable;
   logic        waitrequest;
   logic [63:0] readdata;
   logic        readdatavalid;

   modport slave (
      input  m0_address, m0_burstcount, m0_read,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_burstcount, m1_read, m1_write, m1_writedata, m1_byteenable,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output address, burstcount, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport master (
      output m0_address, m0_burstcount, m0_read,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_burstcount, m1_read, m1_write, m1_writedata, m1_byteenable,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  address, burstcount, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter for one 64-bit Avalon-MM SDRAM port: m0 high priority,
// m1 starvation-protected, in-order read return steered by a tag FIFO.
module sdram_port_arbiter #(
   parameter int unsigned MAX_PENDING  = 16,
   parameter int unsigned STARVE_LIMIT = 32
) (
   input logic             clock,
   input logic             reset_n,
   sdram_port_arbiter_if.slave bus
);
   localparam int unsigned PW = $clog2(MAX_PENDING);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]   PEND_FULL  = (PW+1)'(MAX_PENDING);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;
   typedef struct packed {
      owner_e     owner;
      logic [7:0] bc;
   } tag_t;

   logic          locked_q, locked_d;
   owner_e        owner_q, owner_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [7:0]    word_cnt_q, word_cnt_d;
   logic [7:0]    wr_beats_q, wr_beats_d;
   tag_t          fifo_q [MAX_PENDING];
   tag_t          fifo_d [MAX_PENDING];

   owner_e sel;
   logic   req0, req1, rd_ok, own_rd, own_wr, stall;
   logic   sl_read, sl_write, accept, push, pop, rdv_ok;
   tag_t   head;

   always_comb begin
      req0  = bus.m0_read;
      req1  = bus.m1_read | bus.m1_write;
      rd_ok = (cnt_q != PEND_FULL);

      if (locked_q)
         sel = owner_q;
      else if (req1 && (!req0 || starve_q == STARVE_MAX))
         sel = OWN_M1;
      else
         sel = OWN_M0;

      own_rd   = (sel == OWN_M1) ? bus.m1_read : bus.m0_read;
      own_wr   = (sel == OWN_M1) & bus.m1_write;
      stall    = bus.waitrequest | (own_rd & ~rd_ok);
      sl_read  = reset_n & own_rd & rd_ok;
      sl_write = reset_n & own_wr;

      bus.read       = sl_read;
      bus.write      = sl_write;
      bus.address    = (sel == OWN_M1) ? bus.m1_address    : bus.m0_address;
      bus.burstcount = (sel == OWN_M1) ? bus.m1_burstcount : bus.m0_burstcount;
      bus.writedata  = (sel == OWN_M1) ? bus.m1_writedata  : '0;
      bus.byteenable = (sel == OWN_M1) ? bus.m1_byteenable : '1;

      bus.m0_waitrequest = ~reset_n | (sel != OWN_M0) | stall;
      bus.m1_waitrequest = ~reset_n | (sel != OWN_M1) | stall;

      accept = (sl_read | sl_write) & ~bus.waitrequest;
      push   = sl_read & ~bus.waitrequest;

      // Words arriving with no tag outstanding are dropped without touching state.
      head   = fifo_q[rd_ptr_q];
      rdv_ok = reset_n & bus.readdatavalid & (cnt_q != '0);
      pop    = rdv_ok & (word_cnt_q == head.bc - 8'd1);

      bus.m0_readdata      = bus.readdata;
      bus.m1_readdata      = bus.readdata;
      bus.m0_readdatavalid = rdv_ok & (head.owner == OWN_M0);
      bus.m1_readdatavalid = rdv_ok & (head.owner == OWN_M1);

      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      word_cnt_d = word_cnt_q;
      if (push) begin
         fifo_d[wr_ptr_q].owner = sel;
         fifo_d[wr_ptr_q].bc    = bus.burstcount;
         wr_ptr_d               = wr_ptr_q + 1'b1;
      end
      if (rdv_ok) begin
         word_cnt_d = pop ? '0 : word_cnt_q + 8'd1;
         if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // Remaining beats of an m1 write burst; nonzero pins ownership to m1.
      wr_beats_d = wr_beats_q;
      if (sl_write && !bus.waitrequest)
         wr_beats_d = (wr_beats_q == '0) ? bus.burstcount - 8'd1 : wr_beats_q - 8'd1;

      locked_d = ((sl_read | sl_write) & bus.waitrequest) | (wr_beats_d != '0);
      owner_d  = sel;

      starve_d = starve_q;
      if (!req1 || (accept && sel == OWN_M1))
         starve_d = '0;
      else if (accept && sel == OWN_M0 && starve_q != STARVE_MAX)
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         locked_q   <= 1'b0;
         owner_q    <= OWN_M0;
         starve_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         word_cnt_q <= '0;
         wr_beats_q <= '0;
         for (int unsigned i = 0; i < MAX_PENDING; i++)
            fifo_q[i] <= '0;
      end else begin
         locked_q   <= locked_d;
         owner_q    <= owner_d;
         starve_q   <= starve_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         word_cnt_q <= word_cnt_d;
         wr_beats_q <= wr_beats_d;
         fifo_q     <= fifo_d;
      end
   end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed master stimulus, a small
// SDRAM slave model returning address-derived data, and a read-return monitor.
module tb_sdram_port_arbiter;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   sdram_port_arbiter_if bus();

   sdram_port_arbiter #(.MAX_PENDING(16), .STARVE_LIMIT(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        who;
      logic [63:0] data;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [28:0] addr;
      logic [7:0]  bc;
   } rd_t;
   rd_t pend[$];
   int  rbeat = 0;
   bit  rdv_en = 1'b0;
   bit  bogus = 1'b0;
   bit  cur_real = 1'b0;

   function automatic logic [63:0] dval(input logic [28:0] a);
      return {a, 6'h2A, ~a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   // SDRAM slave: records accepted reads, returns one word per cycle when enabled
   always begin
      @(negedge clock);
      if (reset_n && bus.read && !bus.waitrequest)
         pend.push_back('{bus.address, bus.burstcount});
      if (cur_real) begin
         rbeat++;
         if (rbeat == int'(pend[0].bc)) begin
            void'(pend.pop_front());
            rbeat = 0;
         end
      end
      @(posedge clock);
      #2;
      cur_real = rdv_en && (pend.size() > 0);
      bus.readdatavalid = cur_real | bogus;
      bus.readdata = cur_real ? dval(pend[0].addr + 29'(rbeat)) : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   // Monitor: every returned word must match the head of the expected queue
   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.m0_readdatavalid && bus.m1_readdatavalid)
            chk("rdv_both", 1'b1, 1'b0);
         else if (bus.m0_readdatavalid || bus.m1_readdatavalid) begin
            if (exp_q.size() == 0)
               chk("rdv_unexpected", 1'b1, 1'b0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rdv_who", bus.m1_readdatavalid, e.who);
               chk("rdv_data", bus.m1_readdatavalid ? bus.m1_readdata : bus.m0_readdata, e.data);
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pend.size() != 0) && n < 200) begin
         cyc();
         n++;
      end
      chk("drain_timeout", (n >= 200), 1'b0);
   endtask

   logic [28:0] a;
   logic        a0, a1;

   initial begin
      reset_n = 1'b0;
      bus.m0_address = '0; bus.m0_burstcount = 8'd1; bus.m0_read = 1'b1;
      bus.m1_address = '0; bus.m1_burstcount = 8'd1; bus.m1_read = 1'b0;
      bus.m1_write = 1'b1; bus.m1_writedata = '0; bus.m1_byteenable = '1;
      bus.waitrequest = 1'b0;
      bus.readdatavalid = 1'b0; bus.readdata = '0;
      bogus = 1'b1;

      // Reset: requests and a stray readdatavalid must all be masked
      repeat (2) cyc();
      smp();
      chk("rst_read", bus.read, 1'b0);
      chk("rst_write", bus.write, 1'b0);
      chk("rst_m0_wait", bus.m0_waitrequest, 1'b1);
      chk("rst_m1_wait", bus.m1_waitrequest, 1'b1);
      chk("rst_m0_rdv", bus.m0_readdatavalid, 1'b0);
      chk("rst_m1_rdv", bus.m1_readdatavalid, 1'b0);
      cyc();
      bogus = 1'b0; bus.m0_read = 1'b0; bus.m1_write = 1'b0;
      reset_n = 1'b1;
      cyc();

      // m0 back-to-back reads 0x100..0x10F
      rdv_en = 1'b1;
      bus.m0_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 29'h100 + 29'(i);
         bus.m0_address = a;
         exp_q.push_back('{1'b0, dval(a)});
         smp();
         chk("t1_accept", bus.m0_waitrequest, 1'b0);
         chk("t1_addr", bus.address, a);
         cyc();
      end
      bus.m0_read = 1'b0;
      drain();

      // Both requesting: m1 gets every 33rd accept
      bus.m1_address = 29'h700; bus.m1_writedata = 64'hFEED; bus.m1_write = 1'b1;
      a = 29'h800; bus.m0_address = a; bus.m0_read = 1'b1;
      for (int k = 0; k < 66; k++) begin
         smp();
         a0 = bus.m0_read && !bus.m0_waitrequest;
         a1 = bus.m1_write && !bus.m1_waitrequest;
         chk("t2_grant", {a1, a0}, (k % 33 == 32) ? 2'b10 : 2'b01);
         if (a0) exp_q.push_back('{1'b0, dval(a)});
         cyc();
         if (a0) begin
            a = a + 29'd1;
            bus.m0_address = a;
         end
      end
      bus.m0_read = 1'b0; bus.m1_write = 1'b0;
      drain();

      // Stall: m0 command at 0x200 held for 5 cycles, m1 arrives late
      bus.waitrequest = 1'b1;
      bus.m0_address = 29'h200; bus.m0_read = 1'b1;
      for (int j = 0; j < 5; j++) begin
         smp();
         chk("t3_addr", bus.address, 29'h200);
         chk("t3_m0_wait", bus.m0_waitrequest, 1'b1);
         if (j > 0) chk("t3_m1_wait", bus.m1_waitrequest, 1'b1);
         cyc();
         if (j == 0) begin
            bus.m1_address = 29'h300; bus.m1_read = 1'b1;
         end
      end
      bus.waitrequest = 1'b0;
      smp();
      chk("t3_addr_acc", bus.address, 29'h200);
      chk("t3_m0_acc", bus.m0_waitrequest, 1'b0);
      chk("t3_m1_hold", bus.m1_waitrequest, 1'b1);
      exp_q.push_back('{1'b0, dval(29'h200)});
      cyc();
      bus.m0_read = 1'b0;
      smp();
      chk("t3_m1_acc", bus.m1_waitrequest, 1'b0);
      chk("t3_m1_addr", bus.address, 29'h300);
      exp_q.push_back('{1'b1, dval(29'h300)});
      cyc();
      bus.m1_read = 1'b0;
      drain();

      // Stalled m1 command keeps the port even when high-priority m0 arrives
      bus.waitrequest = 1'b1;
      bus.m1_address = 29'h310; bus.m1_read = 1'b1;
      cyc();
      bus.m0_address = 29'h210; bus.m0_read = 1'b1;
      for (int j = 0; j < 3; j++) begin
         smp();
         chk("t3b_addr", bus.address, 29'h310);
         chk("t3b_m0_wait", bus.m0_waitrequest, 1'b1);
         cyc();
      end
      bus.waitrequest = 1'b0;
      smp();
      chk("t3b_m1_acc", bus.m1_waitrequest, 1'b0);
      exp_q.push_back('{1'b1, dval(29'h310)});
      cyc();
      bus.m1_read = 1'b0;
      smp();
      chk("t3b_m0_acc", bus.m0_waitrequest, 1'b0);
      exp_q.push_back('{1'b0, dval(29'h210)});
      cyc();
      bus.m0_read = 1'b0;
      drain();

      // Tag FIFO full: 17th read stalls until the first word returns
      rdv_en = 1'b0;
      bus.m0_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 29'h400 + 29'(i);
         bus.m0_address = a;
         smp();
         chk("t4_fill", bus.m0_waitrequest, 1'b0);
         exp_q.push_back('{1'b0, dval(a)});
         cyc();
      end
      bus.m0_address = 29'h410;
      for (int j = 0; j < 2; j++) begin
         smp();
         chk("t4_full_read", bus.read, 1'b0);
         chk("t4_full_wait", bus.m0_waitrequest, 1'b1);
         cyc();
      end
      rdv_en = 1'b1;
      smp();
      chk("t4_ret_read", bus.read, 1'b0);
      chk("t4_ret_rdv", bus.m0_readdatavalid, 1'b1);
      cyc();
      smp();
      chk("t4_rel_read", bus.read, 1'b1);
      chk("t4_rel_wait", bus.m0_waitrequest, 1'b0);
      exp_q.push_back('{1'b0, dval(29'h410)});
      cyc();
      bus.m0_read = 1'b0;
      drain();

      // Interleaved bursts: m1 x4 then m0 x2, returned in order
      rdv_en = 1'b0;
      bus.m1_address = 29'h500; bus.m1_burstcount = 8'd4; bus.m1_read = 1'b1;
      smp();
      chk("t5_m1_acc", bus.m1_waitrequest, 1'b0);
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, dval(29'h500 + 29'(i))});
      cyc();
      bus.m1_read = 1'b0;
      bus.m0_address = 29'h600; bus.m0_burstcount = 8'd2; bus.m0_read = 1'b1;
      smp();
      chk("t5_m0_acc", bus.m0_waitrequest, 1'b0);
      for (int i = 0; i < 2; i++) exp_q.push_back('{1'b0, dval(29'h600 + 29'(i))});
      cyc();
      bus.m0_read = 1'b0;
      rdv_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         smp();
         chk("t5_seq", {bus.m1_readdatavalid, bus.m0_readdatavalid}, (k < 4) ? 2'b10 : 2'b01);
         cyc();
      end

      // Stray readdatavalid with nothing outstanding is ignored
      bogus = 1'b1;
      smp();
      chk("bogus_rdv", {bus.m1_readdatavalid, bus.m0_readdatavalid}, 2'b00);
      cyc();
      bogus = 1'b0;
      bus.m1_address = 29'h520; bus.m1_burstcount = 8'd2; bus.m1_read = 1'b1;
      smp();
      chk("t5_post_acc", bus.m1_waitrequest, 1'b0);
      for (int i = 0; i < 2; i++) exp_q.push_back('{1'b1, dval(29'h520 + 29'(i))});
      cyc();
      bus.m1_read = 1'b0;
      drain();

      // m1 write burst of 4 keeps the port against m0
      bus.m1_address = 29'h900; bus.m1_burstcount = 8'd4;
      bus.m1_writedata = 64'h1111_0000; bus.m1_write = 1'b1;
      smp();
      chk("t6_first", {bus.write, bus.m1_waitrequest}, 2'b10);
      cyc();
      bus.m0_address = 29'h620; bus.m0_burstcount = 8'd1; bus.m0_read = 1'b1;
      for (int j = 1; j < 4; j++) begin
         bus.m1_writedata = 64'h1111_0000 + 64'(j);
         smp();
         chk("t6_lock", {bus.write, bus.m0_waitrequest, bus.m1_waitrequest}, 3'b110);
         chk("t6_wdata", bus.writedata, 64'h1111_0000 + 64'(j));
         cyc();
      end
      bus.m1_write = 1'b0;
      smp();
      chk("t6_m0_after", {bus.read, bus.m0_waitrequest}, 2'b10);
      exp_q.push_back('{1'b0, dval(29'h620)});
      cyc();
      bus.m0_read = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
